// File: rtl/scoreboard_hazard_unit_if.sv
// scoreboard_hazard_unit_if: issue/writeback bundle between the issue stage and the scoreboard
interface scoreboard_hazard_unit_if #(
  parameter int NREGS = 32,
  parameter int DEPTH = 5,
  parameter int AW = $clog2(NREGS),
  parameter int LW = $clog2(DEPTH + 1)
);
  logic iss_valid;
  logic [AW-1:0] iss_src_a;
  logic [AW-1:0] iss_src_b;
  logic iss_check_a;
  logic iss_check_b;
  logic iss_writereg;
  logic [AW-1:0] iss_waddr;
  logic [LW-1:0] iss_lat;
  logic flush;
  logic iss_stalled;
  logic iss_lat_err;
  logic wb_valid;
  logic [AW-1:0] wb_addr;
  logic sb_busy;
  modport master (
    output iss_valid, iss_src_a, iss_src_b, iss_check_a, iss_check_b,
    output iss_writereg, iss_waddr, iss_lat, flush,
    input iss_stalled, iss_lat_err, wb_valid, wb_addr, sb_busy
  );
  modport slave (
    input iss_valid, iss_src_a, iss_src_b, iss_check_a, iss_check_b,
    input iss_writereg, iss_waddr, iss_lat, flush,
    output iss_stalled, iss_lat_err, wb_valid, wb_addr, sb_busy
  );
endinterface

// File: rtl/scoreboard_hazard_unit.sv
// scoreboard_hazard_unit: register scoreboard with writeback slot pipeline (RAW/WAW/structural stalls)
// Optional SCOREBOARD_BYPASS_EN: a source being written back this cycle is forwarded instead of stalling.
module scoreboard_hazard_unit #(
  parameter int NREGS = 32,
  parameter int DEPTH = 5,
  parameter int AW = $clog2(NREGS),
  parameter int LW = $clog2(DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  scoreboard_hazard_unit_if.slave sb
);
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic [NREGS-1:0] pending, pending_n;
  logic [DEPTH-1:0] slot_valid, slot_valid_n;
  logic [DEPTH-1:0][AW-1:0] slot_addr, slot_addr_n;
  logic we, raw_a, raw_b, waw, structural, accept;
  assign sb.wb_valid = slot_valid[0];
  assign sb.wb_addr = slot_addr[0];
  assign sb.sb_busy = |pending;
  assign sb.iss_lat_err = sb.iss_valid && sb.iss_writereg &&
                          (sb.iss_lat == '0 || sb.iss_lat > LW'(DEPTH));
  // register 0 is hardwired: writes to it are dropped and never reserve a slot
  assign we = sb.iss_writereg && sb.iss_waddr != '0;
  assign raw_a = sb.iss_check_a && sb.iss_src_a != '0 && pending[sb.iss_src_a] &&
                 !(BYP && sb.wb_valid && sb.wb_addr == sb.iss_src_a);
  assign raw_b = sb.iss_check_b && sb.iss_src_b != '0 && pending[sb.iss_src_b] &&
                 !(BYP && sb.wb_valid && sb.wb_addr == sb.iss_src_b);
  assign waw = sb.iss_writereg && pending[sb.iss_waddr] &&
               !(sb.wb_valid && sb.wb_addr == sb.iss_waddr);
  // slot iss_lat is the one that shifts into iss_lat-1; out-of-range latencies shift to zero
  assign structural = we && |(slot_valid & (DEPTH'(1) << sb.iss_lat));
  assign sb.iss_stalled = sb.iss_valid && (raw_a || raw_b || waw || structural || sb.iss_lat_err);
  assign accept = sb.iss_valid && !sb.iss_stalled && !sb.flush;
  always_comb begin
    pending_n = pending;
    slot_valid_n = slot_valid >> 1;
    slot_addr_n = slot_addr >> AW;
    if (sb.wb_valid) pending_n[sb.wb_addr] = 1'b0;
    if (accept && we) begin
      pending_n[sb.iss_waddr] = 1'b1;
      for (int k = 0; k < DEPTH; k++)
        if (sb.iss_lat == LW'(k + 1)) begin
          slot_valid_n[k] = 1'b1;
          slot_addr_n[k] = sb.iss_waddr;
        end
    end
    if (sb.flush) begin
      pending_n = '0;
      slot_valid_n = '0;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pending <= '0;
      slot_valid <= '0;
      slot_addr <= '0;
    end else begin
      pending <= pending_n;
      slot_valid <= slot_valid_n;
      slot_addr <= slot_addr_n;
    end
endmodule

// File: tb/tb_scoreboard_hazard_unit.sv
// tb_scoreboard_hazard_unit: directed vector table plus randomized run against an in-flight-write list model
module tb_scoreboard_hazard_unit;
  localparam int NREGS = 32;
  localparam int DEPTH = 5;
  localparam int AW = 5;
  localparam int LW = 3;
`ifdef SCOREBOARD_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  scoreboard_hazard_unit_if #(.NREGS(NREGS), .DEPTH(DEPTH)) sb_if ();
  scoreboard_hazard_unit #(.NREGS(NREGS), .DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .sb(sb_if));
  int nvec = 0;
  int nerr = 0;
  typedef struct {
    bit v, ca, cb, wr, fl;
    int sa, sb, wa, lat;
    bit st, le, wv, bz;
    int wad;
  } vec_t;
  vec_t tbl[$];
  typedef struct {int addr; int due;} ent_t;
  ent_t q[$];
  task automatic add(bit v, bit ca, int sa, bit cb, int sb_, bit wr, int wa, int lat, bit fl,
                     bit st, bit le, bit wv, int wad, bit bz);
    vec_t t;
    t.v = v; t.ca = ca; t.sa = sa; t.cb = cb; t.sb = sb_; t.wr = wr; t.wa = wa; t.lat = lat; t.fl = fl;
    t.st = st; t.le = le; t.wv = wv; t.wad = wad; t.bz = bz;
    tbl.push_back(t);
  endtask
  task automatic idle(bit wv, int wad, bit bz);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, wv, wad, bz);
  endtask
  task automatic drive(bit v, bit ca, int sa, bit cb, int sb_, bit wr, int wa, int lat, bit fl);
    sb_if.iss_valid = v;
    sb_if.iss_check_a = ca;
    sb_if.iss_src_a = AW'(sa);
    sb_if.iss_check_b = cb;
    sb_if.iss_src_b = AW'(sb_);
    sb_if.iss_writereg = wr;
    sb_if.iss_waddr = AW'(wa);
    sb_if.iss_lat = LW'(lat);
    sb_if.flush = fl;
  endtask
  task automatic chk(string nm, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask
  task automatic chk_outs(string tag, bit st, bit le, bit wv, int wad, bit bz);
    chk({tag, " iss_stalled"}, int'(sb_if.iss_stalled), int'(st));
    chk({tag, " iss_lat_err"}, int'(sb_if.iss_lat_err), int'(le));
    chk({tag, " wb_valid"}, int'(sb_if.wb_valid), int'(wv));
    if (wv) chk({tag, " wb_addr"}, int'(sb_if.wb_addr), wad);
    chk({tag, " sb_busy"}, int'(sb_if.sb_busy), int'(bz));
  endtask
  function automatic bit pend(int r);
    foreach (q[i]) if (q[i].addr == r) return 1'b1;
    return 1'b0;
  endfunction
  function automatic int wb_at(int c);
    foreach (q[i]) if (q[i].due == c) return q[i].addr;
    return -1;
  endfunction
  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0);
    chk("reset wb_addr", int'(sb_if.wb_addr), 0);
    drive(1, 0, 0, 0, 0, 1, 3, 0, 0);
    #1;
    chk_outs("reset latchk", 1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    reset = 1'b0;
    // write r3 lat 3: writeback in cycle 3, pending gone in cycle 4
    add(1, 0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 1); idle(0, 0, 1); idle(1, 3, 1); idle(0, 0, 0);
    // read-after-write on r3 lat 2: one stall with bypass, two without
    add(1, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0, 0, 0, 0);
    add(1, 1, 3, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 1, 3, 0, 0, 0, 0, 1, 0, !BYP, 0, 1, 3, 1);
    add(!BYP, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // structural: r4 lat4 then r5 lat3 collides
    add(1, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 3, 0, 1, 0, 0, 0, 1);
    idle(0, 0, 1); idle(0, 0, 1); idle(1, 4, 1); idle(0, 0, 0);
    // r4 lat4 then r5 lat2 fits in front
    add(1, 0, 0, 0, 0, 1, 4, 4, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0, 0, 0, 1);
    idle(0, 0, 1); idle(1, 5, 1); idle(1, 4, 1); idle(0, 0, 0);
    // register 0
    add(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    // illegal latency
    add(1, 0, 0, 0, 0, 1, 6, 0, 0, 1, 1, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 6, 6, 0, 1, 1, 0, 0, 0);
    idle(0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 0);
    // flush drops r7 and blocks a same-cycle accept
    add(1, 0, 0, 0, 0, 1, 7, 5, 0, 0, 0, 0, 0, 0);
    idle(0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1);
    repeat (5) idle(0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 8, 1, 1, 0, 0, 0, 0, 0);
    idle(0, 0, 0);
    // source b RAW, WAW cleared by same-cycle writeback
    add(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 1, 9, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    add(1, 0, 0, 0, 0, 1, 9, 3, 0, 0, 0, 1, 9, 1);
    idle(0, 0, 1); idle(0, 0, 1); idle(1, 9, 1); idle(0, 0, 0);
    // WAW stall
    add(1, 0, 0, 0, 0, 1, 10, 3, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 1, 10, 1, 0, 1, 0, 0, 0, 1);
    idle(0, 0, 1); idle(1, 10, 1); idle(0, 0, 0);
    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].ca, tbl[i].sa, tbl[i].cb, tbl[i].sb, tbl[i].wr, tbl[i].wa, tbl[i].lat, tbl[i].fl);
      @(negedge clk);
      chk_outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].le, tbl[i].wv, tbl[i].wad, tbl[i].bz);
      @(posedge clk);
      #1;
    end
    // reset mid-flight drops the pending r7 writeback at once
    drive(1, 0, 0, 0, 0, 1, 7, 5, 0);
    @(negedge clk);
    chk_outs("rst seq issue", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk_outs("rst seq async", 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk_outs("rst seq after", 0, 0, 0, 0, 0);
      @(posedge clk);
      #1;
    end
    // randomized run against the in-flight write list
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit v, ca, cb, wr, fl, le, st, wv, we, acc;
      int sa, sb_, wa, lat, wba;
      v = $urandom_range(0, 3) != 0;
      ca = $urandom_range(0, 1) != 0;
      cb = $urandom_range(0, 1) != 0;
      wr = $urandom_range(0, 2) != 0;
      sa = $urandom_range(0, 7);
      sb_ = $urandom_range(0, 7);
      wa = $urandom_range(0, 7);
      lat = ($urandom_range(0, 11) == 0) ? ($urandom_range(0, 1) != 0 ? 0 : $urandom_range(6, 7))
                                         : $urandom_range(1, DEPTH);
      fl = $urandom_range(0, 59) == 0;
      drive(v, ca, sa, cb, sb_, wr, wa, lat, fl);
      wba = wb_at(cyc);
      wv = wba >= 0;
      we = wr && wa != 0;
      le = v && wr && (lat == 0 || lat > DEPTH);
      st = v && ((ca && sa != 0 && pend(sa) && !(BYP && wba == sa)) ||
                 (cb && sb_ != 0 && pend(sb_) && !(BYP && wba == sb_)) ||
                 (wr && pend(wa) && wba != wa) ||
                 (we && wb_at(cyc + lat) >= 0) || le);
      acc = v && !st && !fl;
      @(negedge clk);
      chk_outs("rand", st, le, wv, wba, q.size() != 0);
      @(posedge clk);
      if (fl) q.delete();
      else begin
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].due == cyc) q.delete(i);
        if (acc && we) q.push_back('{addr: wa, due: cyc + lat});
      end
      #1;
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/scoreboard_hazard_unit.md
SCOREBOARD_HAZARD_UNIT -- requirements
Module: scoreboard_hazard_unit

Interface
REQ-001 Parameters SHALL be: NREGS, 32, architectural register count; DEPTH, 5, max writeback latency in cycles (>=2); AW, $clog2(NREGS), register address width; LW, $clog2(DEPTH+1), latency field width.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 iss_valid  input  1  instruction presented at Issue.
REQ-005 iss_src_a / iss_src_b  input  AW each  source register addresses.
REQ-006 iss_check_a / iss_check_b  input  1 each  source is actually read.
REQ-007 iss_writereg  input  1  instruction writes iss_waddr.
REQ-008 iss_waddr  input  AW  destination register.
REQ-009 iss_lat  input  LW  cycles from issue to writeback, legal 1..DEPTH.
REQ-010 flush  input  1  discard all in-flight entries.
REQ-011 iss_stalled  output  1  Issue may not accept this cycle.
REQ-012 iss_lat_err  output  1  iss_valid with iss_writereg and illegal iss_lat.
REQ-013 wb_valid / wb_addr  output  1 / AW  writeback slot occupied this cycle, and its register.
REQ-014 sb_busy  output  1  any register pending.

Function
REQ-015 State SHALL be pending[NREGS-1:0], slot_valid[DEPTH-1:0], slot_addr[DEPTH-1:0][AW-1:0]; slot k = writeback in k cycles.
REQ-016 accept = iss_valid && !iss_stalled && !flush.
REQ-017 Each edge, slots SHALL shift down one (slot k <= slot k+1, slot DEPTH-1 <= empty); on accept with iss_writereg, slot iss_lat-1 SHALL load {1, iss_waddr} after the shift.
REQ-018 wb_valid = slot_valid[0], wb_addr = slot_addr[0], combinational from state (latency 0).
REQ-019 pending[wb_addr] SHALL clear at edge when wb_valid; pending[iss_waddr] SHALL set on accept with iss_writereg; set wins on same register same cycle.
REQ-020 Register 0 SHALL never become pending, never occupy a slot, never cause a stall.
REQ-021 RAW stall: for each checked source s != 0, stall if pending[s] and not (bypass permitted per REQ-030 and wb_valid and wb_addr == s).
REQ-022 WAW stall: iss_writereg and pending[iss_waddr] and not (wb_valid and wb_addr == iss_waddr).
REQ-023 Structural stall: iss_writereg and iss_lat < DEPTH and slot_valid[iss_lat] (slot that shifts into iss_lat-1).
REQ-024 iss_stalled = iss_valid && (RAW || WAW || structural || iss_lat_err); with iss_valid low it SHALL be 0.
REQ-025 Illegal latency (0 or > DEPTH) SHALL assert iss_lat_err and stall; no state change.
REQ-026 flush SHALL clear all pending and slot_valid at the next edge, overriding accept and writeback-clear; wb outputs for the current cycle stay as computed.
REQ-027 sb_busy = |pending.

Reset
REQ-028 reset SHALL asynchronously clear pending and slot_valid and zero slot_addr; consequently iss_stalled=0 (absent illegal lat), iss_lat_err per inputs, wb_valid=0, wb_addr=0, sb_busy=0.
REQ-029 Reset asserted mid-operation SHALL drop all in-flight writebacks; no wb_valid until a new accept after deassertion.

Configuration
REQ-030 Macro SCOREBOARD_BYPASS_EN: defined -> source matching the register in slot 0 does not stall (forwarded from writeback); undefined -> any pending source stalls until pending clears (one extra cycle).

Verification (DEPTH=5)
REQ-031 Accept write r3 lat=3 at cycle 0 -> wb_valid=1, wb_addr=3 at cycle 3, pending[3]=0 at cycle 4, sb_busy then 0.
REQ-032 Accept r3 lat=2, next cycle read r3 -> stall 1 cycle then accept with SCOREBOARD_BYPASS_EN; stall 2 cycles without.
REQ-033 Accept r4 lat=4 at cycle 0, then r5 lat=3 at cycle 1 -> stalled (structural); r5 lat=2 at cycle 1 -> accepted.
REQ-034 Write r0 lat=1, then read r0 -> no stall, wb_valid never asserts, sb_busy=0.
REQ-035 Pending r7 lat=5, flush at cycle 2 -> cycle 3 sb_busy=0, no wb for r7; reset at cycle 2 instead -> same immediately.
REQ-036 iss_lat=0 and iss_lat=6 with iss_writereg -> iss_lat_err=1, iss_stalled=1, state unchanged.
